// File: rtl/riscv_core_pkg.sv
// Types and constants shared by the core's front-end blocks.
package riscv_core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with clear; clear beats push/pop, push into a full FIFO needs a same-cycle pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o && !clear_i;
    do_push  = push_i && (!full_o || do_pop) && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem read, PC tagging, fetch buffer to decode, branch flush.
module instr_fetch_unit
  import riscv_core_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
);

  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [EW-1:0]     last_q, last_d;
  logic [EW-1:0]     head;
  logic [EW-1:0]     shown;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push_c, pop_c, issue_c, room_c;
  logic [OW-1:0]     occ_next;

  // A taken branch suppresses both the push of a returning word and any pop.
  assign push_c   = (state_q == WAIT) && imem_rvalid && !flush;
  assign pop_c    = out_valid && out_ready && !flush;
  assign occ_next = OW'(fifo_count) + OW'(push_c) - OW'(pop_c);
  assign room_c   = !(fifo_full && !pop_c) && (occ_next < OW'(FIFO_DEPTH));

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    last_d   = last_q;
    issue_c  = 1'b0;
    if (out_valid) last_d = head;
    unique case (state_q)
      IDLE: issue_c = !flush && room_c;
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          issue_c = !flush && room_c;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue_c) begin
      state_d  = WAIT;
      req_pc_d = pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
      last_q   <= {ADDR_W'(0), DATA_W'(NOP_INSTR)};
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      last_q   <= last_d;
    end
  end

  // Request strobes are combinational; gating with reset keeps them quiet while held in reset.
  assign imem_req   = issue_c && reset;
  assign pc_advance = imem_req;
  assign imem_addr  = imem_req ? {pc_in[ADDR_W-1:2], 2'b00} : '0;

  assign out_valid = !fifo_empty;
  assign shown     = out_valid ? head : last_q;
  assign out_pc    = shown[EW-1 -: ADDR_W];
  assign out_instr = shown[DATA_W-1:0];

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .clear_i (flush),
    .wdata_i ({req_pc_q, imem_rdata}),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based reference model checked every cycle.
module tb_instr_fetch_unit;
  import riscv_core_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mrsp_t;

  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           lat = 1;
  bit           use_dead = 0;
  logic [31:0]  target = '0;
  logic [31:0]  pc_next = '0;
  mrsp_t        mq[$];
  fetch_entry_t q[$];
  fetch_entry_t last;
  bit           outstanding = 0;
  bit           dropping = 0;
  logic [31:0]  pend_pc = '0;

  logic         s_valid, s_req, s_adv;
  logic [31:0]  s_addr, s_pc, s_instr;
  logic [1:0]   s_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1111_1111;
      32'h4:   return 32'h2222_2222;
      32'h8:   return use_dead ? 32'hDEAD_BEEF : 32'h3333_3333;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Reference: buffered entries, one outstanding read that may be marked as flushed.
  task automatic compare_cycle();
    fetch_entry_t shown;
    bit           exp_valid, pop, rsp, push, can_issue;
    int           occ;
    logic [31:0]  aligned;
    s_valid = out_valid; s_req = imem_req; s_adv = pc_advance;
    s_addr = imem_addr; s_pc = out_pc; s_instr = out_instr; s_state = dut.state_q;
    if (!reset) begin
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_imem_req", 64'(imem_req), 64'(0));
      chk("rst_pc_advance", 64'(pc_advance), 64'(0));
      chk("rst_imem_addr", 64'(imem_addr), 64'(0));
      chk("rst_out_pc", 64'(out_pc), 64'(0));
      chk("rst_out_instr", 64'(out_instr), 64'(32'h0000_0013));
      q.delete();
      outstanding = 0;
      dropping = 0;
      last = '{pc: 32'h0, instr: NOP_INSTR};
      pc_next = '0;
      return;
    end
    exp_valid = (q.size() != 0);
    shown = exp_valid ? q[0] : last;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_pc", 64'(out_pc), 64'(shown.pc));
    chk("out_instr", 64'(out_instr), 64'(shown.instr));
    pop  = exp_valid && out_ready && !flush;
    rsp  = outstanding && imem_rvalid;
    push = rsp && !dropping && !flush;
    occ  = q.size() - int'(pop) + int'(push) + 1;
    can_issue = !flush && (!outstanding || (rsp && !dropping)) && (occ <= DEPTH);
    aligned = {pc_in[31:2], 2'b00};
    chk("imem_req", 64'(imem_req), 64'(can_issue));
    chk("pc_advance", 64'(pc_advance), 64'(can_issue));
    chk("imem_addr", 64'(imem_addr), can_issue ? 64'(aligned) : 64'(0));
    chk("no_overflow", 64'(dut.u_fifo.push_i & dut.u_fifo.full_o & ~dut.u_fifo.pop_i), 64'(0));
    if (exp_valid) last = q[0];
    if (rsp) begin
      outstanding = 0;
      dropping = 0;
    end
    if (flush) begin
      q.delete();
      if (outstanding) dropping = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pc: pend_pc, instr: imem_rdata});
    end
    if (can_issue) begin
      outstanding = 1;
      pend_pc = pc_in;
      mq.push_back('{due: cyc + lat, data: word_of(aligned)});
    end
    pc_next = flush ? target : (can_issue ? pc_in + 32'd4 : pc_in);
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
    flush = 1'b0;
    pc_in = pc_next;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if (mq.size() != 0 && mq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mq[0].data;
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    pc_in = '0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    mq.delete();
    cycle();
    cycle();
    reset = 1'b1;
    cyc = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_ready = 1'b1;
    // Reset state and first request.
    lat = 1; use_dead = 0;
    do_reset();
    chk("lit_rst_req", 64'(s_req), 64'(0));
    chk("lit_rst_valid", 64'(s_valid), 64'(0));
    chk("lit_rst_nop", 64'(s_instr), 64'(32'h0000_0013));
    cycle();
    chk("lit_first_req", 64'(s_req), 64'(1));
    chk("lit_first_addr", 64'(s_addr), 64'(32'h0));
    cycle();
    cycle();
    chk("lit_c3_pc", 64'(s_pc), 64'(32'h0));
    chk("lit_c3_instr", 64'(s_instr), 64'(32'h1111_1111));
    cycle();
    chk("lit_c4_pc", 64'(s_pc), 64'(32'h4));
    chk("lit_c4_instr", 64'(s_instr), 64'(32'h2222_2222));
    cycle();
    chk("lit_c5_pc", 64'(s_pc), 64'(32'h8));
    chk("lit_c5_instr", 64'(s_instr), 64'(32'h3333_3333));
    repeat (6) cycle();

    // Back-pressure: two entries buffered, fetching stalls, then resumes.
    do_reset();
    out_ready = 1'b0;
    repeat (6) cycle();
    chk("lit_bp_req", 64'(s_req), 64'(0));
    chk("lit_bp_adv", 64'(s_adv), 64'(0));
    chk("lit_bp_valid", 64'(s_valid), 64'(1));
    chk("lit_bp_pc", 64'(s_pc), 64'(32'h0));
    out_ready = 1'b1;
    cycle();
    chk("lit_bp_resume_req", 64'(s_req), 64'(1));
    chk("lit_bp_resume_addr", 64'(s_addr), 64'(32'h8));
    cycle();
    chk("lit_bp_c8_pc", 64'(s_pc), 64'(32'h4));
    cycle();
    chk("lit_bp_c9_pc", 64'(s_pc), 64'(32'h8));
    chk("lit_bp_c9_instr", 64'(s_instr), 64'(32'h3333_3333));
    repeat (3) cycle();

    // Flush while a slow request is pending.
    lat = 3; use_dead = 1;
    do_reset();
    repeat (7) cycle();
    out_ready = 1'b0;
    cycle();
    chk("lit_fl_c8_pc", 64'(s_pc), 64'(32'h4));
    flush = 1'b1; target = 32'hAABB_CCDD;
    cycle();
    cycle();
    chk("lit_fl_drop_valid", 64'(s_valid), 64'(0));
    chk("lit_fl_drop_state", 64'(s_state), 64'(DROP));
    out_ready = 1'b1;
    cycle();
    chk("lit_fl_req", 64'(s_req), 64'(1));
    chk("lit_fl_addr", 64'(s_addr), 64'(32'hAABB_CCDC));
    repeat (3) cycle();
    cycle();
    chk("lit_fl_out_valid", 64'(s_valid), 64'(1));
    chk("lit_fl_out_pc", 64'(s_pc), 64'(32'hAABB_CCDD));
    chk("lit_fl_out_instr", 64'(s_instr), 64'(32'hCCDC_3323));
    repeat (3) cycle();

    // Flush coinciding with the response.
    lat = 1; use_dead = 0;
    do_reset();
    cycle();
    flush = 1'b1; target = 32'h0000_0100;
    cycle();
    chk("lit_fr_no_req", 64'(s_req), 64'(0));
    cycle();
    chk("lit_fr_req", 64'(s_req), 64'(1));
    chk("lit_fr_addr", 64'(s_addr), 64'(32'h100));
    chk("lit_fr_valid", 64'(s_valid), 64'(0));
    cycle();
    cycle();
    chk("lit_fr_out_pc", 64'(s_pc), 64'(32'h100));
    chk("lit_fr_out_instr", 64'(s_instr), 64'(32'h0100_FEFF));
    repeat (2) cycle();

    // Asynchronous reset mid-cycle while waiting, then a stray response.
    do_reset();
    repeat (2) cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("lit_ar_req", 64'(imem_req), 64'(0));
    chk("lit_ar_adv", 64'(pc_advance), 64'(0));
    chk("lit_ar_addr", 64'(imem_addr), 64'(0));
    chk("lit_ar_valid", 64'(out_valid), 64'(0));
    chk("lit_ar_pc", 64'(out_pc), 64'(0));
    chk("lit_ar_instr", 64'(out_instr), 64'(32'h0000_0013));
    mq.delete();
    cycle();
    cycle();
    reset = 1'b1;
    cyc = 1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    cycle();
    chk("lit_stray_valid1", 64'(s_valid), 64'(0));
    cycle();
    chk("lit_stray_valid2", 64'(s_valid), 64'(0));
    cycle();
    chk("lit_stray_pc", 64'(s_pc), 64'(32'h0));
    chk("lit_stray_instr", 64'(s_instr), 64'(32'h1111_1111));
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Consumer end of the program counter's address stream. It takes the current PC, issues single-beat read requests to instruction memory, and tags each returned word with its PC. Fetched pairs are buffered in a small FIFO and presented to decode through a valid/ready handshake. It tells the PC when to advance, and on a taken branch it flushes queued and in-flight fetches.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction word width
FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
pc_in  in  ADDR_W  current PC from program counter
pc_advance  out  1  1-cycle pulse: pc_in accepted, PC may increment/branch
flush  in  1  taken branch (driven alongside branch_instr); discard all older fetches
imem_req  out  1  1-cycle request pulse
imem_addr  out  ADDR_W  request address, word aligned
imem_rvalid  in  1  response valid, ≥1 cycle after imem_req, in order
imem_rdata  in  DATA_W  response word
out_valid  out  1  head FIFO entry valid
out_ready  in  1  decode accepts head entry
out_pc  out  ADDR_W  PC of head entry
out_instr  out  DATA_W  instruction of head entry

Behaviour:
- Reset asserted (async): state=IDLE; FIFO empty; imem_req=0, imem_addr=0, pc_advance=0, out_valid=0, out_pc=0, out_instr=NOP (0x00000013). Reset mid-transaction abandons the fetch; any late imem_rvalid after release is ignored because state is IDLE.
- At most one request outstanding. occupancy = fifo_count + (state==WAIT).
- Issue condition, same cycle, combinational on registered state: can_issue = !flush && occupancy_next < FIFO_DEPTH && (state==IDLE || (state==WAIT && imem_rvalid)). occupancy_next includes this cycle's pop and push.
- On issue: imem_req=1, imem_addr={pc_in[ADDR_W-1:2],2'b00}, pc_advance=1; req_pc register <= pc_in; state <= WAIT.
- States:
  - IDLE: issue if possible, else stay.
  - WAIT: on imem_rvalid, push {req_pc, imem_rdata}. Then issue again (→WAIT) if possible, else →IDLE. Without rvalid, stay.
  - DROP: wait for the response of a flushed fetch. On imem_rvalid, discard the data and →IDLE. No issue in DROP.
- Flush (highest priority, any state): FIFO cleared at the clock edge; no issue and no pc_advance that cycle; a simultaneous pop is ignored.
  - WAIT without rvalid → DROP.
  - WAIT with rvalid → data discarded, → IDLE.
  - IDLE → IDLE.
  - DROP → DROP.
  - Next cycle pc_in holds the branch target; it is fetched first.
- FIFO: push and pop in the same cycle are allowed, including when full or empty. Push-to-empty gives out_valid the next cycle (1-cycle buffer latency). Overflow is impossible by the occupancy rule; the bench asserts it never happens.
- out_pc/out_instr hold while out_valid && !out_ready. When empty they hold the last value (NOP after reset).
- Latency: with memory responding next cycle, a fetch issued at cycle N is visible at out_valid in N+2. Steady-state throughput is 1 instr/cycle with out_ready=1.
- Unaligned pc_in: low 2 bits are cleared on imem_addr only; out_pc carries the raw pc_in.

Decomposition:
- Shared package riscv_core_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DROP}
  - NOP_INSTR = 32'h00000013
  - XLEN = 32
  - fetch_entry_t struct {pc, instr}
- One sub-module, fetch_fifo: parameterised synchronous FIFO with push/pop/clear, count, full/empty. The top keeps the FSM, req_pc and the issue logic.

Test Plan:
- Reset held 0 for 2 cycles, memory idle → imem_req=0, pc_advance=0, out_valid=0, out_instr=0x00000013; after release, first cycle imem_req=1, imem_addr=0x00000000.
- PC 0x0,0x4,0x8 advancing on pc_advance; memory returns 0x11111111,0x22222222,0x33333333 1 cycle after each req; out_ready=1 → outputs (0x0,0x11111111),(0x4,0x22222222),(0x8,0x33333333) on consecutive cycles, first at cycle 3.
- out_ready=0 with 1-cycle memory → exactly 2 entries (0x0,0x4) buffered, then imem_req stays 0 and pc_advance stays 0. Raise out_ready → pops in order and fetching of 0x8 resumes.
- Memory latency 3 cycles; flush with pc_in=0xAABBCCDD while a request for 0x8 is pending → FSM enters DROP and FIFO empties. The late response 0xDEADBEEF is never output; the next req has imem_addr=0xAABBCCDC and out_pc=0xAABBCCDD.
- Flush in the same cycle as imem_rvalid → that word is dropped, no req that cycle, next cycle req to the new pc_in; out_valid=0 in the cycle after the flush.
- Reset driven 0 asynchronously (between clock edges) while in WAIT → all outputs immediately at reset values; an imem_rvalid after release produces no out_valid.
